// File: rtl/redlight_sequencer.sv
// rtl/redlight_sequencer.sv - autonomous press/release timer for the traffic-light receiver
// Keeps a cycle-exact shadow of the receiver light and shortens GREEN for pending pedestrians.
module redlight_sequencer #(
    parameter int GREEN_CYCLES  = 16,
    parameter int YELLOW_CYCLES = 4,
    parameter int RED_CYCLES    = 12,
    parameter int PED_GREEN     = 4,
    parameter int PULSE_LEN     = 2,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       ped_req_i,
    output logic       red_toggle_o,
    output logic [1:0] shadow_light_o,
    output logic       busy_o,
    output logic       ped_ack_o
);

    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b11;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] PED_LOAD    = CNT_W'(PED_GREEN - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        ST_TIMING  = 2'd0,
        ST_PRESS   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [1:0]       shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic             red_q, red_d;
    logic             busy_q, busy_d;
    logic             ped_any;

    assign ped_any = ped_req_i | pending_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pcnt_d    = pcnt_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ack_d     = 1'b0;

        if (ped_req_i && shadow_q != LIGHT_RED) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            ST_TIMING: begin
                // Pedestrian shortening only ever lowers cnt, and works while frozen.
                if (ped_any && shadow_q == LIGHT_GREEN && cnt_q > PED_LOAD) begin
                    cnt_d = PED_LOAD;
                end else if (enable_i) begin
                    if (cnt_q == '0) begin
                        state_d = ST_PRESS;
                        pcnt_d  = PULSE_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_PRESS: begin
                if (pcnt_q == '0) begin
                    state_d = ST_RELEASE;
                end else begin
                    pcnt_d = pcnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // The receiver advances on this same edge.
                state_d = ST_TIMING;
                unique case (shadow_q)
                    LIGHT_GREEN: begin
                        shadow_d = LIGHT_YELLOW;
                        cnt_d    = YELLOW_LOAD;
                    end
                    LIGHT_YELLOW: begin
                        shadow_d = LIGHT_RED;
                        cnt_d    = RED_LOAD;
                        if (ped_any) begin
                            ack_d     = 1'b1;
                            pending_d = 1'b0;
                        end
                    end
                    default: begin
                        shadow_d = LIGHT_GREEN;
                        cnt_d    = GREEN_LOAD;
                    end
                endcase
            end
            default: begin
                state_d = ST_TIMING;
            end
        endcase

        red_d  = (state_d == ST_PRESS);
        busy_d = (state_d != ST_TIMING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_TIMING;
            cnt_q     <= GREEN_LOAD;
            pcnt_q    <= '0;
            shadow_q  <= LIGHT_GREEN;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            red_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            red_q     <= red_d;
            busy_q    <= busy_d;
        end
    end

    assign red_toggle_o   = red_q;
    assign shadow_light_o = shadow_q;
    assign busy_o         = busy_q;
    assign ped_ack_o      = ack_q;

endmodule

// File: tb/tb_redlight_sequencer.sv
// tb/tb_redlight_sequencer.sv - directed and co-simulation bench for redlight_sequencer
module tb_redlight_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       ped_req = 1'b0;
    logic       red_toggle;
    logic [1:0] shadow_light;
    logic       busy;
    logic       ped_ack;

    int passed = 0;
    int total  = 0;

    logic [1:0] rx_light;
    logic       rx_prev;

    redlight_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable),
        .ped_req_i     (ped_req),
        .red_toggle_o  (red_toggle),
        .shadow_light_o(shadow_light),
        .busy_o        (busy),
        .ped_ack_o     (ped_ack)
    );

    always #5 clk = ~clk;

    // Receiver light model: advances when the line falls from pressed to released.
    always @(posedge clk) begin
        if (rst) begin
            rx_light <= 2'b01;
            rx_prev  <= 1'b0;
        end else begin
            rx_prev <= red_toggle;
            if (rx_prev && !red_toggle) begin
                case (rx_light)
                    2'b01:   rx_light <= 2'b11;
                    2'b11:   rx_light <= 2'b10;
                    default: rx_light <= 2'b01;
                endcase
            end
        end
    end

    // Returns at the falling edge of cycle 0 (first cycle out of reset).
    task automatic do_reset(input logic en);
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; ped_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; enable = en;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b1; ped_req = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({red_toggle, shadow_light, busy, ped_ack} !== 5'b0_01_0_0) begin
            $display("FAIL reset_outputs got=%b exp=%b", {red_toggle, shadow_light, busy, ped_ack}, 5'b0_01_0_0);
        end else passed++;
        rst = 1'b0;
        total++;
        if ({red_toggle, shadow_light, busy} !== 4'b0_01_0) begin
            $display("FAIL reset_cycle0 got=%b exp=%b", {red_toggle, shadow_light, busy}, 4'b0_01_0);
        end else passed++;
    endtask

    task automatic test_full_loop();
        logic       exp_red, exp_busy;
        logic [1:0] exp_sh;
        int         m;
        do_reset(1'b1);
        for (int k = 0; k < 82; k++) begin
            m        = k % 41;
            exp_red  = (m == 16 || m == 17 || m == 23 || m == 24 || m == 38 || m == 39);
            exp_busy = exp_red || m == 18 || m == 25 || m == 40;
            exp_sh   = (m < 19) ? 2'b01 : (m < 26) ? 2'b11 : 2'b10;
            total++;
            if (red_toggle !== exp_red) $display("FAIL loop_red cyc=%0d got=%b exp=%b", k, red_toggle, exp_red);
            else passed++;
            total++;
            if (busy !== exp_busy) $display("FAIL loop_busy cyc=%0d got=%b exp=%b", k, busy, exp_busy);
            else passed++;
            total++;
            if (shadow_light !== exp_sh) $display("FAIL loop_shadow cyc=%0d got=%b exp=%b", k, shadow_light, exp_sh);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_cosim();
        int run = 0;
        do_reset(1'b0);
        for (int k = 0; k < 500; k++) begin
            enable = 1'($urandom_range(0, 1));
            total++;
            if (shadow_light !== rx_light) $display("FAIL cosim_shadow cyc=%0d got=%b exp=%b", k, shadow_light, rx_light);
            else passed++;
            if (red_toggle) run++;
            else if (run != 0) begin
                total++;
                if (run != 2) $display("FAIL cosim_pulse_len cyc=%0d got=%0d exp=2", k, run);
                else passed++;
                run = 0;
            end
            @(negedge clk);
        end
        enable = 1'b1;
    endtask

    task automatic test_ped();
        do_reset(1'b1);
        for (int k = 0; k < 61; k++) begin
            if (k == 2 || k == 20) ped_req = 1'b1;
            if (k == 3 || k == 21) ped_req = 1'b0;
            if (k == 6 || k == 9 || k == 48 || k == 49) begin
                total++;
                if (red_toggle !== (k >= 48)) $display("FAIL ped_red cyc=%0d got=%b exp=%b", k, red_toggle, k >= 48);
                else passed++;
            end
            if (k == 7 || k == 8) begin
                total++;
                if (red_toggle !== 1'b1) $display("FAIL ped_short_press cyc=%0d got=%b exp=1", k, red_toggle);
                else passed++;
            end
            if (k == 10) begin
                total++;
                if (shadow_light !== 2'b11) $display("FAIL ped_yellow cyc=%0d got=%b exp=11", k, shadow_light);
                else passed++;
            end
            if (k == 17 || k == 58) begin
                total++;
                if (shadow_light !== 2'b10) $display("FAIL ped_red_entry cyc=%0d got=%b exp=10", k, shadow_light);
                else passed++;
            end
            total++;
            if (ped_ack !== (k == 17)) $display("FAIL ped_ack cyc=%0d got=%b exp=%b", k, ped_ack, k == 17);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_enable_freeze();
        do_reset(1'b1);
        for (int k = 0; k < 40; k++) begin
            if (k == 5)  enable = 1'b0;
            if (k == 25) enable = 1'b1;
            if (k >= 5 && k <= 24) begin
                total++;
                if ({red_toggle, shadow_light} !== 3'b0_01) $display("FAIL freeze_hold cyc=%0d got=%b exp=001", k, {red_toggle, shadow_light});
                else passed++;
            end
            if (k >= 35 && k <= 37) begin
                total++;
                if (red_toggle !== (k != 35)) $display("FAIL freeze_late_press cyc=%0d got=%b exp=%b", k, red_toggle, k != 35);
                else passed++;
            end
            if (k == 38 || k == 39) begin
                total++;
                if (shadow_light !== ((k == 38) ? 2'b01 : 2'b11)) $display("FAIL freeze_advance cyc=%0d got=%b", k, shadow_light);
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enable_drop_in_press();
        do_reset(1'b1);
        for (int k = 0; k < 37; k++) begin
            if (k == 16) enable = 1'b0;
            if (k == 30) enable = 1'b1;
            if (k == 16 || k == 17 || k == 34 || k == 35) begin
                total++;
                if (red_toggle !== 1'b1) $display("FAIL drop_press cyc=%0d got=%b exp=1", k, red_toggle);
                else passed++;
            end
            if (k == 18) begin
                total++;
                if ({red_toggle, busy} !== 2'b01) $display("FAIL drop_release cyc=%0d got=%b exp=01", k, {red_toggle, busy});
                else passed++;
            end
            if (k >= 19 && k <= 33) begin
                total++;
                if ({red_toggle, busy, shadow_light} !== 4'b00_11) $display("FAIL drop_frozen cyc=%0d got=%b exp=0011", k, {red_toggle, busy, shadow_light});
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_in_press();
        do_reset(1'b1);
        repeat (16) @(negedge clk);
        total++;
        if (red_toggle !== 1'b1) $display("FAIL rstpress_pre got=%b exp=1", red_toggle);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({red_toggle, shadow_light, busy} !== 4'b0_01_0) $display("FAIL rstpress_after got=%b exp=0010", {red_toggle, shadow_light, busy});
        else passed++;
        rst = 1'b0;
        for (int j = 0; j < 18; j++) begin
            if (j >= 15) begin
                total++;
                if (red_toggle !== (j != 15)) $display("FAIL rstpress_redwell cyc=%0d got=%b exp=%b", j, red_toggle, j != 15);
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_full_loop();
        test_cosim();
        test_ped();
        test_enable_freeze();
        test_enable_drop_in_press();
        test_rst_in_press();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
